// File: rtl/rx_pkg.sv
// Shared receiver definitions: detector FSM states and the default constants
// agreed with the moving-average filter stage.
package rx_pkg;

  localparam int SPS_DEF        = 32;  // samples per symbol
  localparam int SAMPLE_W       = 18;  // filtered sample width
  localparam int FRAME_BITS_DEF = 8;   // data bits per frame

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    HOLD  = 3'd4
  } rx_state_e;

endpackage

// File: rtl/rx_frame_detector_if.sv
// Sample-in / byte-out bundle between the filter, the frame detector and the
// byte sink. The detector is the slave; the stimulus/sink side is the master.
interface rx_frame_detector_if
  import rx_pkg::*;
#(
  parameter int DATA_W     = SAMPLE_W,
  parameter int FRAME_BITS = FRAME_BITS_DEF
);

  logic signed [DATA_W-1:0]     signal_in;
  logic        [FRAME_BITS-1:0] data_out;
  logic                         data_valid;
  logic                         frame_err;
  logic                         busy;

  modport master (
    output signal_in,
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  signal_in,
    output data_out,
    output data_valid,
    output frame_err,
    output busy
  );

endinterface

// File: rtl/rx_frame_detector.sv
// Frame detector: slices filtered samples against a threshold, finds the
// start bit, samples each symbol at its centre and emits the received byte
// (or a frame-error strobe when the stop bit is wrong). All outputs registered.
module rx_frame_detector
  import rx_pkg::*;
#(
  parameter int SPS        = SPS_DEF,
  parameter int DATA_W     = SAMPLE_W,
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int THRESHOLD  = 0
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  rx_frame_detector_if.slave rx_if
);

  localparam int CNT_W = $clog2(SPS);
  localparam int BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  localparam logic signed [DATA_W-1:0] THR       = DATA_W'(THRESHOLD);
  localparam logic        [CNT_W-1:0]  CNT_HALF  = CNT_W'(SPS / 2 - 1);
  localparam logic        [CNT_W-1:0]  CNT_FULL  = CNT_W'(SPS - 1);
  localparam logic        [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);

  rx_state_e             state_q,    state_d;
  logic [CNT_W-1:0]      cnt_q,      cnt_d;
  logic [BIT_W-1:0]      bit_idx_q,  bit_idx_d;
  logic [FRAME_BITS-1:0] shreg_q,    shreg_d;
  logic [FRAME_BITS-1:0] data_out_q, data_out_d;
  logic                  valid_q,    valid_d;
  logic                  err_q,      err_d;
  logic                  busy_q,     busy_d;
  logic                  d_q;

  // Slicer register: every FSM decision is taken on this registered bit
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      d_q <= 1'b0;
    end else begin
      d_q <= (rx_if.signal_in > THR);
    end
  end

  // FSM, counters, shift register and output registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic: counter cleared on each state entry and each bit sample
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (d_q) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end

      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (d_q) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;  // glitch: too short to be a start bit
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          // New bit enters at the MSB so the first (LSB) bit ends up in bit 0
          shreg_d                 = shreg_q >> 1;
          shreg_d[FRAME_BITS-1]   = d_q;
          if (bit_idx_q == BIT_LAST) begin
            state_d   = STOP;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (!d_q) begin
            data_out_d = shreg_q;
            valid_d    = 1'b1;
            state_d    = IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = HOLD;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      HOLD: begin
        // A stuck-high line must drop before a new start bit is accepted
        cnt_d = '0;
        if (!d_q) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end

      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        bit_idx_d = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign rx_if.data_out   = data_out_q;
  assign rx_if.data_valid = valid_q;
  assign rx_if.frame_err  = err_q;
  assign rx_if.busy       = busy_q;

endmodule

// File: tb/tb_rx_frame_detector.sv
// Directed bench for rx_frame_detector: two instances (threshold 0 and 100),
// strobe monitors that log the cycle and byte of every pulse, and a single
// checking task for all comparisons.
module tb_rx_frame_detector;

  localparam int SPS = 32;
  localparam int DW  = 18;
  localparam int FB  = 8;
  localparam int HI  = 4000;
  localparam int LO  = -4000;
  localparam int E1  = 1 + SPS / 2 + (FB + 1) * SPS + 1;  // cycle stamp of strobe: 306

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  int n_chk = 0;
  int n_bad = 0;

  rx_frame_detector_if #(.DATA_W(DW), .FRAME_BITS(FB)) if_a ();
  rx_frame_detector_if #(.DATA_W(DW), .FRAME_BITS(FB)) if_b ();

  rx_frame_detector #(.SPS(SPS), .DATA_W(DW), .FRAME_BITS(FB), .THRESHOLD(0)) u_dut_a (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .rx_if   (if_a)
  );

  rx_frame_detector #(.SPS(SPS), .DATA_W(DW), .FRAME_BITS(FB), .THRESHOLD(100)) u_dut_b (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .rx_if   (if_b)
  );

  always #5 clk = ~clk;

  // Edge counter used to time-stamp strobes
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitors, sampled on the falling edge
  int         va_cnt = 0, ea_cnt = 0, vb_cnt = 0, ov_cnt = 0;
  int         va_cyc [64];
  logic [7:0] va_byte[64];
  int         ea_cyc [64];
  int         vb_cyc [64];
  logic [7:0] vb_byte[64];

  always @(negedge clk) begin
    if (if_a.data_valid) begin
      if (va_cnt < 64) begin
        va_cyc[va_cnt]  <= cyc;
        va_byte[va_cnt] <= if_a.data_out;
      end
      va_cnt <= va_cnt + 1;
    end
    if (if_a.frame_err) begin
      if (ea_cnt < 64) ea_cyc[ea_cnt] <= cyc;
      ea_cnt <= ea_cnt + 1;
    end
    if (if_b.data_valid) begin
      if (vb_cnt < 64) begin
        vb_cyc[vb_cnt]  <= cyc;
        vb_byte[vb_cnt] <= if_b.data_out;
      end
      vb_cnt <= vb_cnt + 1;
    end
    if ((if_a.data_valid && if_a.frame_err) || (if_b.data_valid && if_b.frame_err))
      ov_cnt <= ov_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one sample to instance A (sel=0) or B (sel=1) and advance one edge
  task automatic tick(input int v, input bit sel);
    if (sel) if_b.signal_in = DW'(v);
    else     if_a.signal_in = DW'(v);
    @(posedge clk);
    #1;
  endtask

  task automatic send_symbol(input int v, input bit sel);
    for (int k = 0; k < SPS; k++) tick(v, sel);
  endtask

  task automatic send_frame(input logic [7:0] b, input int hi, input int lo,
                            input bit stop_hi, input bit sel);
    send_symbol(hi, sel);
    for (int i = 0; i < FB; i++) send_symbol(b[i] ? hi : lo, sel);
    send_symbol(stop_hi ? hi : lo, sel);
  endtask

  int t0, base_v, base_e;

  initial begin
    if_a.signal_in = DW'(LO);
    if_b.signal_in = DW'(LO);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data",  32'(if_a.data_out),   32'h0);
    chk("rst_valid", 32'(if_a.data_valid), 32'h0);
    chk("rst_err",   32'(if_a.frame_err),  32'h0);
    chk("rst_busy",  32'(if_a.busy),       32'h0);
    rst_n = 1'b1;
    repeat (5) tick(LO, 0);

    // Clean frame 0xA5
    base_v = va_cnt; base_e = ea_cnt; t0 = cyc;
    tick(HI, 0); tick(HI, 0);
    chk("a5_busy_start", 32'(if_a.busy), 32'h1);
    for (int k = 2; k < SPS; k++) tick(HI, 0);
    for (int i = 0; i < FB; i++) send_symbol((8'hA5 >> i) & 1 ? HI : LO, 0);
    send_symbol(LO, 0);
    repeat (4) tick(LO, 0);
    chk("a5_nvalid", 32'(va_cnt - base_v), 32'h1);
    chk("a5_vcyc",   32'(va_cyc[base_v] - t0), 32'(E1));
    chk("a5_byte",   32'(va_byte[base_v]), 32'hA5);
    chk("a5_dout",   32'(if_a.data_out), 32'hA5);
    chk("a5_nerr",   32'(ea_cnt - base_e), 32'h0);
    chk("a5_busy",   32'(if_a.busy), 32'h0);

    // Glitch: 8 high samples, start check at edge 17 rejects it
    base_v = va_cnt; base_e = ea_cnt;
    repeat (8) tick(HI, 0);
    repeat (9) tick(LO, 0);             // now just after edge 16
    chk("gl_busy_e16", 32'(if_a.busy), 32'h1);
    tick(LO, 0);                        // just after edge 17
    chk("gl_busy_e17", 32'(if_a.busy), 32'h0);
    repeat (SPS * 10) tick(LO, 0);
    chk("gl_nvalid", 32'(va_cnt - base_v), 32'h0);
    chk("gl_nerr",   32'(ea_cnt - base_e), 32'h0);

    // Bad stop bit, frame 0x3C
    base_v = va_cnt; base_e = ea_cnt; t0 = cyc;
    send_frame(8'h3C, HI, LO, 1'b1, 1'b0);
    repeat (20) tick(HI, 0);
    chk("bs_nerr",   32'(ea_cnt - base_e), 32'h1);
    chk("bs_ecyc",   32'(ea_cyc[base_e] - t0), 32'(E1));
    chk("bs_nvalid", 32'(va_cnt - base_v), 32'h0);
    chk("bs_dout",   32'(if_a.data_out), 32'hA5);
    chk("bs_busy_hold", 32'(if_a.busy), 32'h1);
    repeat (5) tick(LO, 0);
    chk("bs_busy_rel", 32'(if_a.busy), 32'h0);
    chk("bs_nerr2",  32'(ea_cnt - base_e), 32'h1);

    // Threshold boundary on instance B (threshold 100)
    base_v = vb_cnt;
    repeat (40) tick(100, 1);
    chk("th_eq_idle", 32'(if_b.busy), 32'h0);
    tick(101, 1); tick(101, 1);
    chk("th_gt_busy", 32'(if_b.busy), 32'h1);
    repeat (20) tick(100, 1);
    chk("th_glitch", 32'(if_b.busy), 32'h0);
    t0 = cyc;
    send_frame(8'h01, 101, 100, 1'b0, 1'b1);
    repeat (4) tick(100, 1);
    chk("th_nvalid", 32'(vb_cnt - base_v), 32'h1);
    chk("th_byte",   32'(vb_byte[base_v]), 32'h01);
    chk("th_vcyc",   32'(vb_cyc[base_v] - t0), 32'(E1));
    chk("th_dout",   32'(if_b.data_out), 32'h01);
    tick(LO, 1);

    // Back-to-back frames 0x12, 0x34
    base_v = va_cnt; base_e = ea_cnt; t0 = cyc;
    send_frame(8'h12, HI, LO, 1'b0, 1'b0);
    send_frame(8'h34, HI, LO, 1'b0, 1'b0);
    repeat (4) tick(LO, 0);
    chk("bb_nvalid", 32'(va_cnt - base_v), 32'h2);
    chk("bb_byte0",  32'(va_byte[base_v]), 32'h12);
    chk("bb_byte1",  32'(va_byte[base_v + 1]), 32'h34);
    chk("bb_cyc0",   32'(va_cyc[base_v] - t0), 32'(E1));
    chk("bb_gap",    32'(va_cyc[base_v + 1] - va_cyc[base_v]), 32'(10 * SPS));
    chk("bb_nerr",   32'(ea_cnt - base_e), 32'h0);

    // Reset during data bit 4 of frame 0x5A
    base_v = va_cnt; base_e = ea_cnt;
    send_symbol(HI, 0);
    for (int i = 0; i < 4; i++) send_symbol((8'h5A >> i) & 1 ? HI : LO, 0);
    repeat (10) tick(HI, 0);            // bit 4 of 0x5A is 1
    chk("mr_busy_pre", 32'(if_a.busy), 32'h1);
    if_a.signal_in = DW'(LO);
    rst_n = 1'b0;
    #1;
    chk("mr_dout",  32'(if_a.data_out),   32'h0);
    chk("mr_valid", 32'(if_a.data_valid), 32'h0);
    chk("mr_err",   32'(if_a.frame_err),  32'h0);
    chk("mr_busy",  32'(if_a.busy),       32'h0);
    repeat (3) tick(LO, 0);
    rst_n = 1'b1;
    repeat (10) tick(LO, 0);
    t0 = cyc;
    send_frame(8'h77, HI, LO, 1'b0, 1'b0);
    repeat (4) tick(LO, 0);
    chk("mr_nvalid", 32'(va_cnt - base_v), 32'h1);
    chk("mr_byte",   32'(va_byte[base_v]), 32'h77);
    chk("mr_vcyc",   32'(va_cyc[base_v] - t0), 32'(E1));
    chk("mr_nerr",   32'(ea_cnt - base_e), 32'h0);
    chk("mr_dout77", 32'(if_a.data_out), 32'h77);

    // Strobes never overlap on either instance
    chk("no_overlap", 32'(ov_cnt), 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
